sdp_bram_reader: RTL and testbench
==================================

# sdp_bram_reader

Burst read engine for the read port of a simple dual-port block RAM. It accepts a (start address, length) command and issues sequential one-cycle-latency reads (`re`/`ra`/`rd`). The returned words are presented as a valid/ready stream with a last-word flag. It sits between a RAM filled by a writer (DMA, capture logic, boot loader) and any stream consumer, and absorbs the RAM's fixed read latency under consumer backpressure.

## Interface
Parameters:
- `ADDR_WIDTH`, 6, RAM address width; RAM depth is 2**ADDR_WIDTH words
- `DATA_WIDTH`, 32, RAM word width

Ports:
- `clk`  in  1  single clock; all logic is rising-edge
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`
- `cmd_addr`  in  ADDR_WIDTH  first word address
- `cmd_len`  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH
- `mem_re`  out  1  RAM read enable
- `mem_ra`  out  ADDR_WIDTH  RAM read address
- `mem_rd`  in  DATA_WIDTH  RAM read data, valid the cycle after `mem_re`
- `out_valid`  out  1  stream word available
- `out_ready`  in  1  consumer takes the word
- `out_data`  out  DATA_WIDTH  stream word
- `out_last`  out  1  final word of the current command
- `busy`  out  1  command in progress or words still buffered

## Operation
- FSM states: IDLE and READ. `cmd_ready` = (state == IDLE).
- IDLE transitions:
  - On accept with `cmd_len` = 0: stay IDLE. No reads, no output.
  - On accept with `cmd_len` != 0: load the address register and the remaining-count register, then go to READ.
- READ:
  - `mem_re` = 1 when remaining != 0 and (buffered + in_flight) < 4.
  - On each issue: address increments modulo 2**ADDR_WIDTH (wraps 63→0 for the default), and remaining decrements.
  - The issue that takes remaining to 0 is tagged last, and the FSM returns to IDLE on the next edge.
- `mem_ra` shows the address register. It is don't-care when `mem_re` = 0.
- In-flight flag: set on issue. On the following edge, `{last, mem_rd}` is pushed into a 4-entry FIFO.
- Output stream:
  - `out_data`/`out_last` come from the FIFO head. `out_valid` = FIFO not empty.
  - A pop happens on `out_valid && out_ready`.
  - Push and pop on the same edge are both honored.
- Issue decisions use registered state only, so there is no combinational path from `out_ready` to `mem_re`.
- A new command may be accepted while the FIFO still drains the previous one. Words stay in order, and each command's final word carries `out_last`.
- `busy` = (state == READ) | in_flight | FIFO not empty.
- `out_valid` may not drop without a pop. `out_data`/`out_last` stay stable while `out_valid && !out_ready`.

## Timing
- Reset values: `mem_re` = 0, `out_valid` = 0, `out_last` = 0, `busy` = 0, `cmd_ready` = 1 (state IDLE). FIFO, in-flight flag and counters are cleared.
- Reset asserted mid-burst: all outputs go to their reset values immediately. Buffered and in-flight words are discarded, and no further reads are issued.
- Latency with command accepted at edge of cycle 0:
  - `mem_re` is high in cycle 1.
  - `mem_rd` is captured at the end of cycle 2.
  - `out_valid` is high in cycle 3.
- Throughput is one word per cycle while `out_ready` = 1.
- Backpressure: at most 4 words are buffered, and `mem_re` stalls until a slot frees.
- Command turnaround: the next command can be accepted in the cycle after the last issue.

## Structure
- Package `sdp_bram_reader_pkg` holds the state enum typedef (IDLE, READ) and the localparam `FIFO_DEPTH` = 4.
- Sub-module `sdp_bram_reader_fifo` is a 4-entry synchronous FIFO of width DATA_WIDTH+1, with 2-bit pointers plus a count, and the same `clk`/`rst_n`.
- The top level holds the FSM, the address/remaining counters and the in-flight flag.

## Test plan
- **Basic burst:** RAM preloaded with word[i] = 3*i, `cmd_addr` = 0x10, `cmd_len` = 4, `out_ready` = 1. Required: `mem_re` high in cycles 1–4 with `mem_ra` 0x10–0x13; `out_data` 0x30, 0x33, 0x36, 0x39 in cycles 3–6; `out_last` only on 0x39.
- **Wrap-around:** `cmd_addr` = 62, `cmd_len` = 4. Required: `mem_ra` 62, 63, 0, 1, with data in that order.
- **Backpressure:** `cmd_len` = 8, `out_ready` = 0 for cycles 0–9 then 1. Required: exactly 4 `mem_re` pulses before the release, no loss or duplication, 8 ordered words, last on the 8th.
- **Zero length:** `cmd_len` = 0. Required: no `mem_re`, no `out_valid`, `cmd_ready` stays 1, `busy` stays 0.
- **Back-to-back commands:** (0, 2) then (0x20, 3) offered immediately. Required: second command accepted while the FIFO still holds words; 5 words in order; `out_last` on word 2 and word 5.
- **Reset mid-burst:** `rst_n` low during cycle 4 of an 8-word burst. Required: `out_valid`/`mem_re`/`busy` drop asynchronously; after release `cmd_ready` = 1 and no stale words appear.

Source files
------------

// File: rtl/sdp_bram_reader_pkg.sv
// Shared types and constants for the block-RAM burst reader.
package sdp_bram_reader_pkg;

  localparam int FIFO_DEPTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

endpackage

// File: rtl/sdp_bram_reader_fifo.sv
// Four-entry synchronous FIFO that absorbs RAM read data under consumer backpressure.
module sdp_bram_reader_fifo
  import sdp_bram_reader_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [2:0]       count
);

  localparam logic [2:0] FULL_COUNT = 3'(FIFO_DEPTH);
  localparam logic [1:0] PTR_ONE    = 2'd1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [1:0]       wptr;
  logic [1:0]       rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == 3'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != FULL_COUNT) || do_pop);
  assign head    = mem[rptr];

  // NOTE: storage carries no reset; entries are only read once the count says they were written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      count <= count + 3'(do_push) - 3'(do_pop);
    end
  end

endmodule

// File: rtl/sdp_bram_reader.sv
// Burst read engine: issues sequential one-cycle-latency RAM reads and streams the words out.
module sdp_bram_reader
  import sdp_bram_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_ra,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;
  localparam logic [3:0]            DEPTH4   = 4'(FIFO_DEPTH);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   rem_q;
  logic                  in_flight_q;
  logic                  in_flight_last_q;
  logic [2:0]            fifo_count;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_head;
  logic [3:0]            occupancy;
  logic                  accept;
  logic                  issue;
  logic                  last_issue;

  assign cmd_ready  = (state_q == IDLE);
  assign accept     = cmd_ready && cmd_valid && (cmd_len != '0);

  // Credits count words already buffered plus the one still in the RAM pipeline,
  // so the decision depends on registers only and never on out_ready.
  assign occupancy  = {1'b0, fifo_count} + 4'(in_flight_q);
  assign issue      = (state_q == READ) && (rem_q != '0) && (occupancy < DEPTH4);
  assign last_issue = issue && (rem_q == REM_ONE);

  assign mem_re     = issue;
  assign mem_ra     = addr_q;
  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_head[DATA_WIDTH-1:0];
  assign out_last   = fifo_head[DATA_WIDTH];
  assign busy       = (state_q == READ) || in_flight_q || !fifo_empty;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)     state_d = READ;
      READ: if (last_issue) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      rem_q            <= '0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      in_flight_q      <= issue;
      in_flight_last_q <= last_issue;
      if (accept) begin
        addr_q <= cmd_addr;
        rem_q  <= cmd_len;
      end else if (issue) begin
        addr_q <= addr_q + ADDR_ONE;
        rem_q  <= rem_q - REM_ONE;
      end
    end
  end

  sdp_bram_reader_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_flight_q),
    .push_data ({in_flight_last_q, mem_rd}),
    .pop       (out_ready),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_sdp_bram_reader.sv
// Directed bench for sdp_bram_reader: cycle table plus multi-cycle burst sequences.
module tb_sdp_bram_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_addr;
  logic [6:0]  cmd_len;
  logic        mem_re;
  logic [5:0]  mem_ra;
  logic [31:0] mem_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ram [64];
  logic [31:0] data_q [$];
  logic        last_q [$];
  logic [5:0]  ra_q [$];
  int          re_count = 0;

  typedef struct {
    logic        cv;
    logic [5:0]  addr;
    logic [6:0]  len;
    logic        rdy;
    logic        e_re;
    logic [5:0]  e_ra;
    logic        e_ov;
    logic [31:0] e_data;
    logic        e_last;
    logic        e_busy;
    logic        e_crdy;
  } vec_t;

  vec_t vecs [$];

  sdp_bram_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .mem_re    (mem_re),
    .mem_ra    (mem_ra),
    .mem_rd    (mem_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // One-cycle-latency RAM read port.
  always @(posedge clk) if (mem_re) mem_rd <= ram[mem_ra];

  always @(negedge clk) begin
    if (mem_re) begin
      re_count++;
      ra_q.push_back(mem_ra);
    end
    if (out_valid && out_ready) begin
      data_q.push_back(out_data);
      last_q.push_back(out_last);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic cv, input logic [5:0] addr, input logic [6:0] len,
                              input logic rdy, input logic e_re, input logic [5:0] e_ra,
                              input logic e_ov, input logic [31:0] e_data, input logic e_last,
                              input logic e_busy, input logic e_crdy);
    vec_t v;
    v.cv = cv; v.addr = addr; v.len = len; v.rdy = rdy;
    v.e_re = e_re; v.e_ra = e_ra; v.e_ov = e_ov; v.e_data = e_data;
    v.e_last = e_last; v.e_busy = e_busy; v.e_crdy = e_crdy;
    return v;
  endfunction

  task automatic clear_mon();
    data_q.delete();
    last_q.delete();
    ra_q.delete();
    re_count = 0;
  endtask

  // Offers a command from the current cycle until accepted; returns with the accept edge passed.
  task automatic send_cmd(input logic [5:0] a, input logic [6:0] l,
                          output int waited, output logic ov_at_accept);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    waited    = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    ov_at_accept = out_valid;
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int c = 0;
    while (data_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("word_count", 32'(data_q.size()), 32'(n));
  endtask

  task automatic check_stream(input string tag, input logic [31:0] ed [$], input logic el [$]);
    for (int i = 0; i < ed.size(); i++) begin
      if (i < data_q.size()) begin
        check($sformatf("%s_data%0d", tag, i), data_q[i], ed[i]);
        check($sformatf("%s_last%0d", tag, i), 32'(last_q[i]), 32'(el[i]));
      end
    end
  endtask

  initial begin
    int          waited;
    logic        ov_acc;
    logic [31:0] ed [$];
    logic        el [$];

    for (int i = 0; i < 64; i++) ram[i] = 32'(3 * i);
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_re",    32'(mem_re),    32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic burst (0x10, 4), then a zero-length command.
    vecs.push_back(mk(1, 6'h10, 7'd4, 1,  0, 6'h00,  0, 32'h00, 0,  0, 1));
    vecs.push_back(mk(0, 6'h00, 7'd0, 1,  1, 6'h10,  0, 32'h00, 0,  1, 0));
    vecs.push_back(mk(0, 6'h00, 7'd0, 1,  1, 6'h11,  0, 32'h00, 0,  1, 0));
    vecs.push_back(mk(0, 6'h00, 7'd0, 1,  1, 6'h12,  1, 32'h30, 0,  1, 0));
    vecs.push_back(mk(0, 6'h00, 7'd0, 1,  1, 6'h13,  1, 32'h33, 0,  1, 0));
    vecs.push_back(mk(0, 6'h00, 7'd0, 1,  0, 6'h00,  1, 32'h36, 0,  1, 1));
    vecs.push_back(mk(0, 6'h00, 7'd0, 1,  0, 6'h00,  1, 32'h39, 1,  1, 1));
    vecs.push_back(mk(0, 6'h00, 7'd0, 1,  0, 6'h00,  0, 32'h00, 0,  0, 1));
    vecs.push_back(mk(1, 6'h05, 7'd0, 1,  0, 6'h00,  0, 32'h00, 0,  0, 1));
    vecs.push_back(mk(0, 6'h00, 7'd0, 1,  0, 6'h00,  0, 32'h00, 0,  0, 1));
    vecs.push_back(mk(0, 6'h00, 7'd0, 1,  0, 6'h00,  0, 32'h00, 0,  0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      cmd_valid = vecs[i].cv;
      cmd_addr  = vecs[i].addr;
      cmd_len   = vecs[i].len;
      out_ready = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("v%0d_mem_re", i),    32'(mem_re),    32'(vecs[i].e_re));
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d_busy", i),      32'(busy),      32'(vecs[i].e_busy));
      check($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].e_crdy));
      if (vecs[i].e_re) check($sformatf("v%0d_mem_ra", i), 32'(mem_ra), 32'(vecs[i].e_ra));
      if (vecs[i].e_ov) begin
        check($sformatf("v%0d_out_data", i), out_data, vecs[i].e_data);
        check($sformatf("v%0d_out_last", i), 32'(out_last), 32'(vecs[i].e_last));
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;

    // Wrap-around: 62, 63, 0, 1.
    clear_mon();
    send_cmd(6'd62, 7'd4, waited, ov_acc);
    wait_words(4, 40);
    check("wrap_re_count", 32'(re_count), 32'd4);
    if (ra_q.size() == 4) begin
      check("wrap_ra0", 32'(ra_q[0]), 32'd62);
      check("wrap_ra1", 32'(ra_q[1]), 32'd63);
      check("wrap_ra2", 32'(ra_q[2]), 32'd0);
      check("wrap_ra3", 32'(ra_q[3]), 32'd1);
    end
    ed = '{32'd186, 32'd189, 32'd0, 32'd3};
    el = '{1'b0, 1'b0, 1'b0, 1'b1};
    check_stream("wrap", ed, el);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: 8 words from 0x04, consumer stalled through cycle 9.
    clear_mon();
    out_ready = 1'b0;
    send_cmd(6'd4, 7'd8, waited, ov_acc);
    repeat (9) @(negedge clk);
    #1;
    check("bp_re_before_release", 32'(re_count), 32'd4);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_data",  out_data, 32'd12);
    check("bp_hold_last",  32'(out_last), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_words(8, 60);
    check("bp_re_total", 32'(re_count), 32'd8);
    ed.delete();
    el.delete();
    for (int i = 0; i < 8; i++) begin
      ed.push_back(32'(3 * (4 + i)));
      el.push_back(i == 7);
    end
    check_stream("bp", ed, el);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back commands: (0, 2) then (0x20, 3).
    clear_mon();
    send_cmd(6'd0, 7'd2, waited, ov_acc);
    send_cmd(6'h20, 7'd3, waited, ov_acc);
    check("b2b_accept_wait", 32'(waited), 32'd2);
    check("b2b_fifo_nonempty_at_accept", 32'(ov_acc), 32'd1);
    wait_words(5, 40);
    ed = '{32'h0, 32'h3, 32'h60, 32'h63, 32'h66};
    el = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    check_stream("b2b", ed, el);
    repeat (3) @(posedge clk);
    #1;

    // Reset asserted during cycle 4 of an 8-word burst.
    clear_mon();
    send_cmd(6'd0, 7'd8, waited, ov_acc);
    repeat (3) @(posedge clk);
    #2;
    check("mid_pre_mem_re",    32'(mem_re),    32'd1);
    check("mid_pre_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_re",    32'(mem_re),    32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_words",     32'(data_q.size()), 32'd0);
    check("post_rst_re_count",  32'(re_count),      32'd0);
    check("post_rst_cmd_ready", 32'(cmd_ready),     32'd1);
    check("post_rst_busy",      32'(busy),          32'd0);

    // Single-word command after reset.
    send_cmd(6'd7, 7'd1, waited, ov_acc);
    wait_words(1, 20);
    ed = '{32'd21};
    el = '{1'b1};
    check_stream("single", ed, el);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
